quad_phase_decoder: RTL and testbench
=====================================

Name: quad_phase_decoder

Overview:
- Receiving end of the angle/quadrant sweep interface that feeds the CORDIC core.
- Takes the folded first-quadrant angle `ang` (8.8 fixed-point degrees, 0..90°) and the 2-bit quadrant `qrt`, and rebuilds the absolute phase over 0..360°.
- Also produces the sine/cosine sign flags, counts revolutions, and checks that the stream is a legal forward sweep (range, quadrant order, step size).
- Sits between the sweep generator and the CORDIC output sign-correction stage, and serves as a bench/debug monitor.

Parameters:
- ANG_W, 16, width of `ang`; 8.8 fixed-point degrees.
- QUARTER, 23040, 90° in 8.8 (90 << 8).
- MAX_STEP, 32, largest legal forward phase increment per sample, in 8.8 LSBs.
- REV_W, 16, width of the revolution counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `ang`/`qrt` sample is valid this cycle.
- ang  in  ANG_W  folded angle, 8.8 degrees, legal range 0..QUARTER.
- qrt  in  2  quadrant: 00 rising, 01 falling, 10 rising, 11 falling.
- err_clr  in  1  clears the sticky error flags.
- out_valid  out  1  registered copy of in_valid.
- phase  out  18  absolute phase, 8.8 degrees, 0..92159.
- sin_neg  out  1  sine sign negative (qrt[1]).
- cos_neg  out  1  cosine sign negative (qrt[1]^qrt[0]).
- rev_cnt  out  REV_W  completed revolutions, wraps modulo 2^REV_W.
- range_err  out  1  sticky: `ang` > QUARTER was seen.
- seq_err  out  1  sticky: quadrant skipped or went backwards.
- step_err  out  1  sticky: phase delta outside 0..MAX_STEP.
- locked  out  1  FSM is in TRACK.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = SYNC.
  - prev_phase = 0, prev_qrt = 0.
- Latency and handshake:
  - Exactly one cycle from input to output: out_valid(t+1) = in_valid(t).
  - When out_valid is 0, phase and sign flags hold their last value.
  - There is no backpressure.
- Saturation: a = min(ang, QUARTER). If ang > QUARTER, set range_err.
- Phase mapping (unsigned, 18-bit):
  - qrt 00: phase = a
  - qrt 01: phase = 2·QUARTER − a
  - qrt 10: phase = 2·QUARTER + a
  - qrt 11: phase = 4·QUARTER − a
  - A result of 4·QUARTER (92160) is forced to 0.
- Sign flags are registered together with phase.
- FSM has two states:
  - SYNC: on in_valid, capture prev_phase/prev_qrt, emit the output, perform no sequence/step check, go to TRACK.
  - TRACK: on each in_valid, perform the checks below, then update prev_phase/prev_qrt.
- Checks in TRACK:
  - Quadrant check: qrt must equal prev_qrt or prev_qrt+1 (mod 4). Otherwise set seq_err and go to SYNC; this sample is still output and captured.
  - Step check: delta = (phase − prev_phase) mod 92160, computed as phase − prev_phase, plus 92160 if negative. If delta > MAX_STEP, set step_err and stay in TRACK. delta = 0 is legal (saturation dwell at 0°/90°).
  - Revolution count: increment rev_cnt when prev_qrt = 11 and qrt = 00, in TRACK only.
- Error flags:
  - Sticky; cleared only by err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag = 1).
- locked = (state == TRACK).
- Reset mid-stream: rst has priority over everything; it returns the FSM to SYNC and clears rev_cnt. The next sample re-synchronises the decoder.
- No arithmetic is wider than 18 bits; a 19-bit signed intermediate is used for delta.

Decomposition:
- Shared package `cordic_pkg` holds:
  - QUARTER, HALF (46080), FULL (92160)
  - the quadrant encodings Q_RISE0=00, Q_FALL1=01, Q_RISE2=10, Q_FALL3=11
  - the FSM state enum {SYNC, TRACK}
- One natural sub-module: `quad_unfold`, purely combinational, mapping (ang, qrt) to (phase, sin_neg, cos_neg, range flag). The top level owns the FSM, registers, checks and counter.

Test Plan:
- Reset then in_valid with ang=0x1E00 (30°), qrt=00 → next cycle out_valid=1, phase=7680, sin_neg=0, cos_neg=0, locked=1, no errors.
- Sweep ang=QUARTER−15 in qrt=01, then ang=QUARTER in qrt=00 → seq_err=1 (backwards quadrant), locked=0 on the following cycle. Then err_clr → seq_err=0.
- ang=0x5A0F (above QUARTER) with qrt=10 → range_err=1, phase=69120 (270°).
- Forward sweep steps of 15: qrt=11 ang=15 (phase 92145), then qrt=00 ang=0 → phase=0, delta=15, rev_cnt increments 0→1, no step_err.
- In qrt=00, jump ang 100 → 200 → step_err=1 (delta 100 > 32). locked stays 1.
- Assert rst mid-sweep with rev_cnt=3 → all outputs 0, locked=0. The next sample is accepted without seq/step checks.

Source files
------------

// File: rtl/quad_phase_decoder_pkg.sv
// Shared constants, quadrant encodings and FSM states for the
// angle/quadrant sweep path into the CORDIC core.
package cordic_pkg;

    localparam int QUARTER = 23040;
    localparam int HALF    = 46080;
    localparam int FULL    = 92160;

    localparam logic [1:0] Q_RISE0 = 2'b00;
    localparam logic [1:0] Q_FALL1 = 2'b01;
    localparam logic [1:0] Q_RISE2 = 2'b10;
    localparam logic [1:0] Q_FALL3 = 2'b11;

    typedef enum logic {
        SYNC,
        TRACK
    } state_e;

endpackage

// File: rtl/quad_phase_decoder_if.sv
// Sample stream in, decoded phase/status out.
interface quad_phase_decoder_if #(
    parameter int ANG_W = 16,
    parameter int REV_W = 16
);
    logic             in_valid;
    logic [ANG_W-1:0] ang;
    logic [1:0]       qrt;
    logic             err_clr;
    logic             out_valid;
    logic [17:0]      phase;
    logic             sin_neg;
    logic             cos_neg;
    logic [REV_W-1:0] rev_cnt;
    logic             range_err;
    logic             seq_err;
    logic             step_err;
    logic             locked;

    modport master (
        output in_valid, ang, qrt, err_clr,
        input  out_valid, phase, sin_neg, cos_neg, rev_cnt,
        input  range_err, seq_err, step_err, locked
    );

    modport slave (
        input  in_valid, ang, qrt, err_clr,
        output out_valid, phase, sin_neg, cos_neg, rev_cnt,
        output range_err, seq_err, step_err, locked
    );

endinterface

// File: rtl/quad_phase_decoder_unfold.sv
// Combinational unfold of (first-quadrant angle, quadrant) into
// absolute 0..360 degree phase plus sine/cosine sign flags.
module quad_unfold #(
    parameter int ANG_W   = 16,
    parameter int QUARTER = cordic_pkg::QUARTER
) (
    input  logic [ANG_W-1:0] i_ang,
    input  logic [1:0]       i_qrt,
    output logic [17:0]      o_phase,
    output logic             o_sin_neg,
    output logic             o_cos_neg,
    output logic             o_over
);
    import cordic_pkg::*;

    localparam logic [17:0] L_Q = 18'(QUARTER);
    localparam logic [17:0] L_H = 18'(2 * QUARTER);
    localparam logic [17:0] L_F = 18'(4 * QUARTER);

    logic [17:0] w_a;
    logic [17:0] w_raw;

    assign o_over = (18'(i_ang) > L_Q);
    assign w_a    = o_over ? L_Q : 18'(i_ang);

    always_comb begin
        w_raw = w_a;
        unique case (i_qrt)
            Q_RISE0: w_raw = w_a;
            Q_FALL1: w_raw = L_H - w_a;
            Q_RISE2: w_raw = L_H + w_a;
            Q_FALL3: w_raw = L_F - w_a;
            default: w_raw = w_a;
        endcase
    end

    // 360 degrees folds back onto 0
    assign o_phase   = (w_raw == L_F) ? 18'd0 : w_raw;
    assign o_sin_neg = i_qrt[1];
    assign o_cos_neg = i_qrt[1] ^ i_qrt[0];

endmodule

// File: rtl/quad_phase_decoder.sv
// Rebuilds absolute phase from the folded sweep stream, counts
// revolutions and flags illegal range, quadrant order or step size.
module quad_phase_decoder #(
    parameter int ANG_W    = 16,
    parameter int QUARTER  = cordic_pkg::QUARTER,
    parameter int MAX_STEP = 32,
    parameter int REV_W    = 16
) (
    input logic                 clk,
    input logic                 rst,
    quad_phase_decoder_if.slave bus
);
    import cordic_pkg::*;

    localparam logic [18:0] L_FULL = 19'(4 * QUARTER);
    localparam logic [18:0] L_STEP = 19'(MAX_STEP);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [17:0]      r_prev_phase;
    logic [1:0]       r_prev_qrt;
    logic             r_out_valid;
    logic [17:0]      r_phase;
    logic             r_sin_neg;
    logic             r_cos_neg;
    logic [REV_W-1:0] r_rev_cnt;
    logic             r_range_err;
    logic             r_seq_err;
    logic             r_step_err;

    logic [17:0]      w_phase;
    logic             w_sin_neg;
    logic             w_cos_neg;
    logic             w_over;
    logic [18:0]      w_diff;
    logic [18:0]      w_delta;
    logic             w_qrt_ok;
    logic             w_wrap;
    logic             w_range_new;
    logic             w_seq_new;
    logic             w_step_new;
    logic             w_rev_inc;

    quad_unfold #(
        .ANG_W   (ANG_W),
        .QUARTER (QUARTER)
    ) u_unfold (
        .i_ang     (bus.ang),
        .i_qrt     (bus.qrt),
        .o_phase   (w_phase),
        .o_sin_neg (w_sin_neg),
        .o_cos_neg (w_cos_neg),
        .o_over    (w_over)
    );

    // Forward distance modulo 360 degrees; bit 18 is the borrow
    assign w_diff   = {1'b0, w_phase} - {1'b0, r_prev_phase};
    assign w_delta  = w_diff[18] ? (w_diff + L_FULL) : w_diff;
    assign w_qrt_ok = (bus.qrt == r_prev_qrt) ||
                      (bus.qrt == 2'(r_prev_qrt + 2'd1));
    assign w_wrap   = (r_prev_qrt == Q_FALL3) && (bus.qrt == Q_RISE0);

    always_comb begin
        w_state_nxt = r_state;
        w_seq_new   = 1'b0;
        w_step_new  = 1'b0;
        w_rev_inc   = 1'b0;
        w_range_new = bus.in_valid & w_over;
        if (bus.in_valid) begin
            unique case (r_state)
                SYNC: w_state_nxt = TRACK;
                TRACK: begin
                    if (!w_qrt_ok) begin
                        w_seq_new   = 1'b1;
                        w_state_nxt = SYNC;
                    end else begin
                        w_step_new = (w_delta > L_STEP);
                        w_rev_inc  = w_wrap;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SYNC;
            r_prev_phase <= '0;
            r_prev_qrt   <= '0;
            r_out_valid  <= 1'b0;
            r_phase      <= '0;
            r_sin_neg    <= 1'b0;
            r_cos_neg    <= 1'b0;
            r_rev_cnt    <= '0;
            r_range_err  <= 1'b0;
            r_seq_err    <= 1'b0;
            r_step_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_prev_phase <= w_phase;
                r_prev_qrt   <= bus.qrt;
                r_phase      <= w_phase;
                r_sin_neg    <= w_sin_neg;
                r_cos_neg    <= w_cos_neg;
            end
            if (w_rev_inc) begin
                r_rev_cnt <= r_rev_cnt + 1'b1;
            end
            // A fresh error outranks a simultaneous clear
            r_range_err <= (r_range_err & ~bus.err_clr) | w_range_new;
            r_seq_err   <= (r_seq_err & ~bus.err_clr) | w_seq_new;
            r_step_err  <= (r_step_err & ~bus.err_clr) | w_step_new;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.phase     = r_phase;
    assign bus.sin_neg   = r_sin_neg;
    assign bus.cos_neg   = r_cos_neg;
    assign bus.rev_cnt   = r_rev_cnt;
    assign bus.range_err = r_range_err;
    assign bus.seq_err   = r_seq_err;
    assign bus.step_err  = r_step_err;
    assign bus.locked    = (r_state == TRACK);

endmodule

// File: tb/tb_quad_phase_decoder.sv
// Directed scoreboard bench for quad_phase_decoder.
module tb_quad_phase_decoder;

    localparam int QUARTER = 23040;

    typedef struct {
        logic [17:0] ph;
        logic        sn;
        logic        cn;
        logic [15:0] rev;
        logic        re;
        logic        se;
        logic        st;
        logic        lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    quad_phase_decoder_if bus ();

    quad_phase_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag);
        exp_t e;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".phase"}, 32'(bus.phase), 32'(e.ph));
            chk({tag, ".sin_neg"}, 32'(bus.sin_neg), 32'(e.sn));
            chk({tag, ".cos_neg"}, 32'(bus.cos_neg), 32'(e.cn));
            chk({tag, ".rev_cnt"}, 32'(bus.rev_cnt), 32'(e.rev));
            chk({tag, ".range_err"}, 32'(bus.range_err), 32'(e.re));
            chk({tag, ".seq_err"}, 32'(bus.seq_err), 32'(e.se));
            chk({tag, ".step_err"}, 32'(bus.step_err), 32'(e.st));
            chk({tag, ".locked"}, 32'(bus.locked), 32'(e.lk));
        end
    endtask

    task automatic send(input string tag, input logic [15:0] a,
                        input logic [1:0] q, input logic clr,
                        input logic [17:0] ph, input logic sn,
                        input logic cn, input logic [15:0] rev,
                        input logic re, input logic se, input logic st,
                        input logic lk);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ang      = a;
        bus.qrt      = q;
        bus.err_clr  = clr;
        e = '{ph, sn, cn, rev, re, se, st, lk};
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        chk_out(tag);
    endtask

    task automatic clr_cycle();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".phase"}, 32'(bus.phase), 32'd0);
        chk({tag, ".sin_neg"}, 32'(bus.sin_neg), 32'd0);
        chk({tag, ".cos_neg"}, 32'(bus.cos_neg), 32'd0);
        chk({tag, ".rev_cnt"}, 32'(bus.rev_cnt), 32'd0);
        chk({tag, ".range_err"}, 32'(bus.range_err), 32'd0);
        chk({tag, ".seq_err"}, 32'(bus.seq_err), 32'd0);
        chk({tag, ".step_err"}, 32'(bus.step_err), 32'd0);
        chk({tag, ".locked"}, 32'(bus.locked), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.ang      = '0;
        bus.qrt      = 2'b00;
        bus.err_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // First sample locks, no checks
        send("lock30", 16'h1E00, 2'b00, 1'b0,
             18'd7680, 0, 0, 16'd0, 0, 0, 0, 1);
        // Big forward jump into quadrant 1
        send("q1_jump", 16'(QUARTER - 15), 2'b01, 1'b0,
             18'd23055, 0, 1, 16'd0, 0, 0, 1, 1);
        // Backwards quadrant drops lock
        send("q_back", 16'(QUARTER), 2'b00, 1'b0,
             18'd23040, 0, 0, 16'd0, 0, 1, 1, 0);

        clr_cycle();
        chk("clr.seq_err", 32'(bus.seq_err), 32'd0);
        chk("clr.step_err", 32'(bus.step_err), 32'd0);
        chk("clr.out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr.phase_hold", 32'(bus.phase), 32'd23040);
        chk("clr.locked", 32'(bus.locked), 32'd0);

        // Over-range saturates to 270 degrees, resyncs
        send("range", 16'h5A0F, 2'b10, 1'b0,
             18'd69120, 1, 1, 16'd0, 1, 0, 0, 1);
        send("q3_15", 16'd15, 2'b11, 1'b0,
             18'd92145, 1, 0, 16'd0, 1, 0, 1, 1);
        // Wrap to 0 with a 15 LSB step, clearing flags together
        send("wrap0", 16'd0, 2'b00, 1'b1,
             18'd0, 0, 0, 16'd1, 0, 0, 0, 1);

        // New error beats simultaneous clear
        send("jump100", 16'd100, 2'b00, 1'b1,
             18'd100, 0, 0, 16'd1, 0, 0, 1, 1);
        send("jump200", 16'd200, 2'b00, 1'b0,
             18'd200, 0, 0, 16'd1, 0, 0, 1, 1);
        clr_cycle();
        chk("clr2.step_err", 32'(bus.step_err), 32'd0);
        chk("clr2.phase_hold", 32'(bus.phase), 32'd200);
        chk("clr2.locked", 32'(bus.locked), 32'd1);
        send("step15", 16'd215, 2'b00, 1'b0,
             18'd215, 0, 0, 16'd1, 0, 0, 0, 1);

        for (int k = 0; k < 2; k++) begin
            send("rev_q1", 16'(QUARTER), 2'b01, 1'b0,
                 18'd23040, 0, 1, 16'(1 + k), 0, 0, 1, 1);
            send("rev_q2", 16'd0, 2'b10, 1'b0,
                 18'd46080, 1, 1, 16'(1 + k), 0, 0, 1, 1);
            send("rev_q3", 16'(QUARTER), 2'b11, 1'b0,
                 18'd69120, 1, 0, 16'(1 + k), 0, 0, 1, 1);
            send("rev_q0", 16'd0, 2'b00, 1'b0,
                 18'd0, 0, 0, 16'(2 + k), 0, 0, 1, 1);
        end
        chk("rev3", 32'(bus.rev_cnt), 32'd3);

        // Reset beats a concurrent sample
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.ang      = 16'd50;
        bus.qrt      = 2'b00;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk_zero("midrst");

        // prev_qrt=00 -> 10 would be a skip if checked
        send("resync", 16'd5, 2'b10, 1'b0,
             18'd46085, 1, 1, 16'd0, 0, 0, 0, 1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
